// File: rtl/line_write_buffer.sv
// rtl/line_write_buffer.sv - two-slot cache-line write buffer with drain FSM and read-conflict check
//
// Absorbs 8-word dirty lines from the writeback controller one word per cycle
// and drains them, in push order, to main-memory port A whenever it is granted.
// Reads about to be allocated are checked against buffered lines so a refill
// never fetches stale memory data.
//
// Optional feature macro: WBUF_FORWARD_EN
//   defined   : FULL/DRAINING matching lines are forwarded (rd_hit/rd_dout),
//               only FILLING matches raise rd_conflict
//   undefined : any buffered match raises rd_conflict, rd_hit/rd_dout are 0
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_we/in_addr/in_din/in_last     writeback push, in_ready = push accepted
//   mem_req/mem_grant/mem_we         drain handshake (mem_we = mem_req & mem_grant)
//   mem_addr/mem_din                 drain word address and data
//   rd_addr/rd_conflict/rd_hit/rd_dout  allocate-read check and forward
//   empty                            both slots empty
//   err                              sticky protocol error
module line_write_buffer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 13,
    parameter int LINE_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_din,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_req,
    input  logic              mem_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_conflict,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_dout,
    output logic              empty,
    output logic              err
);

    localparam int TAG_W = ADDR_W - 3;

    localparam logic [1:0] S_EMPTY    = 2'd0;
    localparam logic [1:0] S_FILLING  = 2'd1;
    localparam logic [1:0] S_FULL     = 2'd2;
    localparam logic [1:0] S_DRAINING = 2'd3;

    localparam logic [0:0] D_IDLE = 1'b0;
    localparam logic [0:0] D_RUN  = 1'b1;

    logic [1:0]        slot_st  [0:1];
    logic [TAG_W-1:0]  slot_tag [0:1];
    // Word storage, indexed {slot, offset}; not reset, its contents are
    // meaningless while the owning slot is EMPTY.
    logic [DATA_W-1:0] line_mem [0:2*LINE_WORDS-1];

    logic        fill_ptr;
    logic        drain_ptr;
    logic [2:0]  fill_cnt;
    logic [2:0]  drain_cnt;
    logic [0:0]  d_state;

    logic [1:0]       fill_st;
    logic             push;
    logic [2:0]       in_off;
    logic [TAG_W-1:0] in_tag;
    logic             tag_bad;
    logic             off_bad;
    logic             last_bad;
    logic             line_done;

    // ------------------------------------------------------------------
    // Fill side
    // ------------------------------------------------------------------
    assign fill_st   = slot_st[fill_ptr];
    assign in_ready  = (fill_st == S_EMPTY) || (fill_st == S_FILLING);
    assign push      = in_we && in_ready;
    assign in_off    = in_addr[2:0];
    assign in_tag    = in_addr[ADDR_W-1:3];
    // The first push of a line defines the tag, so only later pushes can mismatch.
    assign tag_bad   = (fill_st == S_FILLING) && (in_tag != slot_tag[fill_ptr]);
    assign off_bad   = (in_off != fill_cnt);
    assign last_bad  = in_last && (fill_cnt != 3'd7);
    assign line_done = push && in_last && (fill_cnt == 3'd7);

    // ------------------------------------------------------------------
    // Drain side
    // ------------------------------------------------------------------
    assign mem_req  = (d_state == D_RUN);
    assign mem_we   = mem_req && mem_grant;
    assign mem_addr = mem_req ? {slot_tag[drain_ptr], drain_cnt} : '0;
    assign mem_din  = mem_req ? line_mem[{drain_ptr, drain_cnt}] : '0;

    assign empty = (slot_st[0] == S_EMPTY) && (slot_st[1] == S_EMPTY);

    // ------------------------------------------------------------------
    // Allocate-read check
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] rd_tag;
    logic [1:0]       rd_match;

    assign rd_tag      = rd_addr[ADDR_W-1:3];
    assign rd_match[0] = (slot_st[0] != S_EMPTY) && (slot_tag[0] == rd_tag);
    assign rd_match[1] = (slot_st[1] != S_EMPTY) && (slot_tag[1] == rd_tag);

`ifdef WBUF_FORWARD_EN
    logic rd_win;
    logic rd_fill_match;

    // The slot not under the drain pointer holds the newer copy of a line.
    assign rd_win        = rd_match[~drain_ptr] ? ~drain_ptr : drain_ptr;
    assign rd_fill_match = (rd_match[0] && (slot_st[0] == S_FILLING)) ||
                           (rd_match[1] && (slot_st[1] == S_FILLING));
    assign rd_conflict   = rd_fill_match;
    assign rd_hit        = (|rd_match) && !rd_fill_match;
    assign rd_dout       = rd_hit ? line_mem[{rd_win, rd_addr[2:0]}] : '0;
`else
    logic unused_rd_off;

    assign unused_rd_off = ^rd_addr[2:0];
    assign rd_conflict   = |rd_match;
    assign rd_hit        = 1'b0;
    assign rd_dout       = '0;
`endif

    // ------------------------------------------------------------------
    // Word storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            line_mem[{fill_ptr, in_off}] <= in_din;
        end
    end

    // ------------------------------------------------------------------
    // Slot state, pointers, counters, drain FSM, error flag.
    // Fill only touches EMPTY/FILLING slots and drain only FULL/DRAINING
    // slots, so both can update slot_st in the same cycle without colliding.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_st[i]  <= S_EMPTY;
                slot_tag[i] <= '0;
            end
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            fill_cnt  <= 3'd0;
            drain_cnt <= 3'd0;
            d_state   <= D_IDLE;
            err       <= 1'b0;
        end else begin
            // Bad pushes are still written; only the flag records the fault.
            if ((in_we && !in_ready) || (push && (tag_bad || off_bad || last_bad))) begin
                err <= 1'b1;
            end

            if (push) begin
                if (fill_st == S_EMPTY) begin
                    slot_tag[fill_ptr] <= in_tag;
                    slot_st[fill_ptr]  <= S_FILLING;
                end
                if (line_done) begin
                    slot_st[fill_ptr] <= S_FULL;
                    fill_ptr          <= ~fill_ptr;
                    fill_cnt          <= 3'd0;
                end else begin
                    fill_cnt <= fill_cnt + 3'd1;
                end
            end

            case (d_state)
                D_IDLE: begin
                    if (slot_st[drain_ptr] == S_FULL) begin
                        slot_st[drain_ptr] <= S_DRAINING;
                        drain_cnt          <= 3'd0;
                        d_state            <= D_RUN;
                    end
                end
                default: begin
                    if (mem_we) begin
                        drain_cnt <= drain_cnt + 3'd1;
                        if (drain_cnt == 3'd7) begin
                            slot_st[drain_ptr] <= S_EMPTY;
                            drain_ptr          <= ~drain_ptr;
                            d_state            <= D_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_write_buffer.sv
// tb/tb_line_write_buffer.sv - directed self-checking bench for line_write_buffer
module tb_line_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_we = 1'b0;
    logic [12:0] in_addr = '0;
    logic [31:0] in_din = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        mem_req;
    logic        mem_grant = 1'b0;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din;
    logic [12:0] rd_addr = '0;
    logic        rd_conflict;
    logic        rd_hit;
    logic [31:0] rd_dout;
    logic        empty;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    line_write_buffer #(.DATA_W(32), .ADDR_W(13), .LINE_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .in_we(in_we), .in_addr(in_addr), .in_din(in_din), .in_last(in_last),
        .in_ready(in_ready),
        .mem_req(mem_req), .mem_grant(mem_grant), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .rd_addr(rd_addr), .rd_conflict(rd_conflict), .rd_hit(rd_hit), .rd_dout(rd_dout),
        .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_we = 1'b0; in_last = 1'b0; mem_grant = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic push(input logic [12:0] a, input logic [31:0] d, input logic last);
        in_we = 1'b1; in_addr = a; in_din = d; in_last = last;
        tick;
        in_we = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset;
        rd_addr = 13'h0;
        do_reset;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (rd_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_rd_conflict: got %b want 0", rd_conflict); end
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit: got %b want 0", rd_hit); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (mem_addr !== 13'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_din !== 32'h0) begin n_fail++; $display("FAIL reset_mem_din: got %h want 0", mem_din); end
        n_checks++; if (rd_dout !== 32'h0) begin n_fail++; $display("FAIL reset_rd_dout: got %h want 0", rd_dout); end
    endtask

    task automatic test_single_line;
        do_reset;
        mem_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(13'(32'h40 + i), 32'hA0 + 32'(i), i == 7);
            if (i == 0) begin
                n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_after_push: got %b want 0", empty); end
            end
        end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_at_last_edge: got %b want 0", mem_req); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        tick;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL single_we[%0d]: got %b want 1", i, mem_we); end
            n_checks++; if (mem_addr !== 13'(32'h40 + i)) begin n_fail++; $display("FAIL single_addr[%0d]: got %h want %h", i, mem_addr, 13'(32'h40 + i)); end
            n_checks++; if (mem_din !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL single_din[%0d]: got %h want %h", i, mem_din, 32'hA0 + 32'(i)); end
            tick;
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_end: got %b want 1", empty); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_end: got %b want 0", mem_req); end
    endtask

    task automatic test_back_to_back;
        int e;
        int budget;
        logic [12:0] ea;
        logic [31:0] ed;
        do_reset;
        for (int i = 0; i < 8; i++) push(13'(32'h40 + i), 32'hA0 + 32'(i), i == 7);
        for (int i = 0; i < 8; i++) push(13'(32'h80 + i), 32'hB0 + 32'(i), i == 7);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_mem_req: got %b want 1", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 13'h040) begin n_fail++; $display("FAIL b2b_hold_addr: got %h want 040", mem_addr); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err_before: got %b want 0", err); end
        push(13'h0C0, 32'hDEAD, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL b2b_err_drop: got %b want 1", err); end
        mem_grant = 1'b1;
        #1;
        e = 0; budget = 0;
        while (e < 16 && budget < 40) begin
            ea = (e < 8) ? 13'(32'h40 + e) : 13'(32'h80 + e - 8);
            ed = (e < 8) ? 32'hA0 + 32'(e) : 32'hB0 + 32'(e - 8);
            if (mem_req) begin
                n_checks++; if (mem_addr !== ea) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h want %h", e, mem_addr, ea); end
                n_checks++; if (mem_din !== ed) begin n_fail++; $display("FAIL b2b_din[%0d]: got %h want %h", e, mem_din, ed); end
                if (mem_we) e++;
            end
            tick;
            budget++;
        end
        n_checks++; if (e != 16) begin n_fail++; $display("FAIL b2b_timeout: got %0d words want 16", e); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty_end: got %b want 1", empty); end
    endtask

    task automatic test_grant_toggle;
        int e;
        int cyc;
        logic [12:0] ea;
        logic [31:0] ed;
        do_reset;
        mem_grant = 1'b1;
        for (int i = 0; i < 8; i++) push(13'(32'h40 + i), 32'hA0 + 32'(i), i == 7);
        e = 0; cyc = 0;
        while (e < 16 && cyc < 60) begin
            if (cyc < 8) begin
                in_we = 1'b1; in_addr = 13'(32'h100 + cyc); in_din = 32'hC0 + 32'(cyc); in_last = (cyc == 7);
            end else begin
                in_we = 1'b0; in_last = 1'b0;
            end
            mem_grant = (cyc % 2 == 0);
            #1;
            if (cyc < 8) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL toggle_in_ready[%0d]: got %b want 1", cyc, in_ready); end
            end
            ea = (e < 8) ? 13'(32'h40 + e) : 13'(32'h100 + e - 8);
            ed = (e < 8) ? 32'hA0 + 32'(e) : 32'hC0 + 32'(e - 8);
            if (mem_req) begin
                n_checks++; if (mem_we !== mem_grant) begin n_fail++; $display("FAIL toggle_we[%0d]: got %b want %b", cyc, mem_we, mem_grant); end
                n_checks++; if (mem_addr !== ea) begin n_fail++; $display("FAIL toggle_addr[%0d]: got %h want %h", e, mem_addr, ea); end
                n_checks++; if (mem_din !== ed) begin n_fail++; $display("FAIL toggle_din[%0d]: got %h want %h", e, mem_din, ed); end
                if (mem_grant) e++;
            end
            tick;
            cyc++;
        end
        in_we = 1'b0; in_last = 1'b0;
        n_checks++; if (e != 16) begin n_fail++; $display("FAIL toggle_timeout: got %0d words want 16", e); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL toggle_empty_end: got %b want 1", empty); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL toggle_err: got %b want 0", err); end
    endtask

    task automatic test_forward;
        logic exp_conf;
        logic exp_hit;
        logic [31:0] exp_dout;
`ifdef WBUF_FORWARD_EN
        exp_conf = 1'b0; exp_hit = 1'b1; exp_dout = 32'hA5;
`else
        exp_conf = 1'b1; exp_hit = 1'b0; exp_dout = 32'h0;
`endif
        do_reset;
        rd_addr = 13'h045;
        for (int i = 0; i < 4; i++) push(13'(32'h40 + i), 32'hA0 + 32'(i), 1'b0);
        n_checks++; if (rd_conflict !== 1'b1) begin n_fail++; $display("FAIL fwd_filling_conflict: got %b want 1", rd_conflict); end
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_filling_hit: got %b want 0", rd_hit); end
        rd_addr = 13'h085;
        #1;
        n_checks++; if (rd_conflict !== 1'b0) begin n_fail++; $display("FAIL fwd_nomatch_conflict: got %b want 0", rd_conflict); end
        rd_addr = 13'h045;
        for (int i = 4; i < 8; i++) push(13'(32'h40 + i), 32'hA0 + 32'(i), i == 7);
        n_checks++; if (rd_conflict !== exp_conf) begin n_fail++; $display("FAIL fwd_full_conflict: got %b want %b", rd_conflict, exp_conf); end
        n_checks++; if (rd_hit !== exp_hit) begin n_fail++; $display("FAIL fwd_full_hit: got %b want %b", rd_hit, exp_hit); end
        n_checks++; if (rd_dout !== exp_dout) begin n_fail++; $display("FAIL fwd_full_dout: got %h want %h", rd_dout, exp_dout); end
        tick;
        mem_grant = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (rd_conflict !== exp_conf) begin n_fail++; $display("FAIL fwd_drain_conflict[%0d]: got %b want %b", i, rd_conflict, exp_conf); end
            n_checks++; if (rd_dout !== exp_dout) begin n_fail++; $display("FAIL fwd_drain_dout[%0d]: got %h want %h", i, rd_dout, exp_dout); end
            tick;
        end
        n_checks++; if (rd_conflict !== 1'b0) begin n_fail++; $display("FAIL fwd_after_conflict: got %b want 0", rd_conflict); end
        n_checks++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_after_hit: got %b want 0", rd_hit); end
        n_checks++; if (rd_dout !== 32'h0) begin n_fail++; $display("FAIL fwd_after_dout: got %h want 0", rd_dout); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fwd_after_empty: got %b want 1", empty); end
        rd_addr = 13'h0;
    endtask

    task automatic test_offset_err_and_reset;
        do_reset;
        push(13'h040, 32'hA0, 1'b0);
        push(13'h041, 32'hA1, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oerr_before: got %b want 0", err); end
        push(13'h043, 32'hA3, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oerr_set: got %b want 1", err); end
        for (int i = 3; i < 8; i++) push(13'(32'h40 + i), 32'hA0 + 32'(i), i == 7);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oerr_sticky: got %b want 1", err); end
        mem_grant = 1'b1;
        tick; tick;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL oerr_mid_req: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== 13'h041) begin n_fail++; $display("FAIL oerr_mid_addr: got %h want 041", mem_addr); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b want 0", mem_req); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b want 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        n_checks++; if (mem_din !== 32'h0) begin n_fail++; $display("FAIL rst_mid_din: got %h want 0", mem_din); end
        mem_grant = 1'b0;
    endtask

    task automatic test_tag_and_last_err;
        do_reset;
        push(13'h040, 32'h1, 1'b0);
        push(13'h081, 32'h2, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tag_err: got %b want 1", err); end
        do_reset;
        push(13'h040, 32'h1, 1'b1);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL early_last_err: got %b want 1", err); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL early_last_no_full: got %b want 0", mem_req); end
        tick;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL early_last_no_drain: got %b want 0", mem_req); end
    endtask

    initial begin
        test_reset;
        test_single_line;
        test_back_to_back;
        test_grant_toggle;
        test_forward;
        test_offset_err_and_reset;
        test_tag_and_last_err;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
